// File: rtl/osd_regaccess_package.sv
// Shared types for the OSD register-access handler: DII flit, packet type
// encodings, base register map and the handler FSM state enum.
package osd_regaccess_package;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        valid;
  } dii_flit;

  // Subtype field, bits [13:10] of the type flit
  localparam logic [3:0] REQ_READ       = 4'b0000;
  localparam logic [3:0] REQ_WRITE      = 4'b0001;
  localparam logic [3:0] RESP_READ      = 4'b1000;
  localparam logic [3:0] RESP_WRITE     = 4'b1001;
  localparam logic [3:0] RESP_READ_ERR  = 4'b1010;
  localparam logic [3:0] RESP_WRITE_ERR = 4'b1011;

  // Base register map; everything from REG_MOD_BASE upward is module-owned
  localparam logic [15:0] REG_MOD_VENDOR  = 16'h0000;
  localparam logic [15:0] REG_MOD_TYPE    = 16'h0001;
  localparam logic [15:0] REG_MOD_VERSION = 16'h0002;
  localparam logic [15:0] REG_EVENT_DEST  = 16'h0003;
  localparam logic [15:0] REG_MOD_CS      = 16'h0004;
  localparam logic [15:0] REG_MOD_BASE    = 16'h0200;

  typedef enum logic [3:0] {
    RX_DEST, RX_SRC, RX_TYPE, RX_ADDR, RX_WDATA, RX_DRAIN,
    ACCESS, TX_DEST, TX_SRC, TX_TYPE, TX_DATA
  } state_t;

  // Full type flit for a given subtype
  function automatic logic [15:0] type_word(input logic [3:0] sub);
    return {2'b00, sub, 10'b0};
  endfunction

  function automatic logic [3:0] resp_subtype(input logic is_write, input logic err);
    if (is_write) return err ? RESP_WRITE_ERR : RESP_WRITE;
    return err ? RESP_READ_ERR : RESP_READ;
  endfunction

endpackage

// File: rtl/osd_regaccess_baseregs.sv
// Base register block: identification constants, event_dest and MOD_CS.
// Writes land on the clock edge that ends the ACCESS cycle.
module osd_regaccess_baseregs
  import osd_regaccess_package::*;
#(
  parameter logic [15:0] MOD_VENDOR  = 16'h0,
  parameter logic [15:0] MOD_TYPE    = 16'h0,
  parameter logic [15:0] MOD_VERSION = 16'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        access,
  input  logic        is_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        err,
  output logic [15:0] event_dest,
  output logic        stall
);

  logic [15:0] event_dest_q;
  logic        active_q;

  // Writable base registers
  always_ff @(posedge clk) begin
    if (rst) begin
      event_dest_q <= 16'h0;
      active_q     <= 1'b0;
    end else if (access && is_write) begin
      if (addr == REG_EVENT_DEST) event_dest_q <= wdata;
      if (addr == REG_MOD_CS)     active_q     <= wdata[0];
    end
  end

  // Read mux and error decode; ID registers reject writes
  always_comb begin
    rdata = 16'h0;
    err   = 1'b0;
    case (addr)
      REG_MOD_VENDOR: begin
        rdata = MOD_VENDOR;
        err   = is_write;
      end
      REG_MOD_TYPE: begin
        rdata = MOD_TYPE;
        err   = is_write;
      end
      REG_MOD_VERSION: begin
        rdata = MOD_VERSION;
        err   = is_write;
      end
      REG_EVENT_DEST: rdata = event_dest_q;
      REG_MOD_CS:     rdata = {15'h0, active_q};
      default:        err   = 1'b1;
    endcase
  end

  assign event_dest = event_dest_q;
  assign stall      = ~active_q;

endmodule

// File: rtl/osd_regaccess_handler.sv
// DII register-access handler: receives read/write request packets, serves
// base registers internally, forwards others to the module register port,
// and returns a response packet.
// Optional macro OSD_REGACCESS_TIMEOUT_EN adds a reg_ack timeout counter.
module osd_regaccess_handler
  import osd_regaccess_package::*;
#(
  parameter logic [15:0] MOD_VENDOR  = 16'h0,
  parameter logic [15:0] MOD_TYPE    = 16'h0,
  parameter logic [15:0] MOD_VERSION = 16'h0,
  parameter logic [7:0]  TIMEOUT     = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id,
  input  dii_flit     in,
  output logic        in_ready,
  output dii_flit     out,
  input  logic        out_ready,
  output logic        reg_request,
  output logic        reg_write,
  output logic [15:0] reg_addr,
  output logic [15:0] reg_wdata,
  input  logic        reg_ack,
  input  logic        reg_err,
  input  logic [15:0] reg_rdata,
  output logic [15:0] event_dest,
  output logic        stall
);

  state_t      state;
  logic [15:0] src_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        is_write_q;
  logic        err_q;
  logic        reg_request_q;
`ifdef OSD_REGACCESS_TIMEOUT_EN
  logic [7:0]  timeout_cnt_q;
`endif

  logic        type_ok;
  logic        type_is_write;
  logic        base_access;
  logic        base_hit;
  logic [15:0] base_rdata;
  logic        base_err;
  logic        resp_has_data;

  // Request type decode of the flit currently on the input
  always_comb begin
    type_ok       = (in.data[15:14] == 2'b00) && (in.data[9:0] == 10'h0) &&
                    (in.data[13:10] == REQ_READ || in.data[13:10] == REQ_WRITE);
    type_is_write = type_ok && (in.data[13:10] == REQ_WRITE);
  end

  assign base_hit      = addr_q < REG_MOD_BASE;
  assign base_access   = (state == ACCESS) && base_hit;
  assign resp_has_data = !is_write_q && !err_q;

  osd_regaccess_baseregs #(
    .MOD_VENDOR  (MOD_VENDOR),
    .MOD_TYPE    (MOD_TYPE),
    .MOD_VERSION (MOD_VERSION)
  ) u_baseregs (
    .clk        (clk),
    .rst        (rst),
    .access     (base_access),
    .is_write   (is_write_q),
    .addr       (addr_q),
    .wdata      (wdata_q),
    .rdata      (base_rdata),
    .err        (base_err),
    .event_dest (event_dest),
    .stall      (stall)
  );

  // Packet framing and access sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RX_DEST;
      src_q         <= 16'h0;
      addr_q        <= 16'h0;
      wdata_q       <= 16'h0;
      rdata_q       <= 16'h0;
      is_write_q    <= 1'b0;
      err_q         <= 1'b0;
      reg_request_q <= 1'b0;
`ifdef OSD_REGACCESS_TIMEOUT_EN
      timeout_cnt_q <= 8'h0;
`endif
    end else begin
      unique case (state)
        RX_DEST: if (in.valid) state <= in.last ? RX_DEST : RX_SRC;
        RX_SRC: if (in.valid) begin
          src_q <= in.data;
          state <= in.last ? RX_DEST : RX_TYPE;
        end
        RX_TYPE: if (in.valid) begin
          is_write_q <= type_is_write;
          err_q      <= !type_ok;
          if (in.last)       state <= RX_DEST;
          else if (!type_ok) state <= RX_DRAIN;
          else               state <= RX_ADDR;
        end
        RX_ADDR: if (in.valid) begin
          addr_q <= in.data;
          if (is_write_q) begin
            state <= in.last ? RX_DEST : RX_WDATA;
          end else if (in.last) begin
            state <= ACCESS;
          end else begin
            err_q <= 1'b1;
            state <= RX_DRAIN;
          end
        end
        RX_WDATA: if (in.valid) begin
          wdata_q <= in.data;
          if (in.last) begin
            state <= ACCESS;
          end else begin
            err_q <= 1'b1;
            state <= RX_DRAIN;
          end
        end
        // Oversized or malformed packets are swallowed, then answered with an error
        RX_DRAIN: if (in.valid && in.last) state <= TX_DEST;
        ACCESS: begin
          if (base_hit) begin
            err_q   <= base_err;
            rdata_q <= base_rdata;
            state   <= TX_DEST;
          end else if (!reg_request_q) begin
            reg_request_q <= 1'b1;
          end else if (reg_ack) begin
            reg_request_q <= 1'b0;
            err_q         <= reg_err;
            rdata_q       <= reg_rdata;
            state         <= TX_DEST;
`ifdef OSD_REGACCESS_TIMEOUT_EN
            timeout_cnt_q <= 8'h0;
          end else if (timeout_cnt_q + 8'd1 == TIMEOUT) begin
            reg_request_q <= 1'b0;
            err_q         <= 1'b1;
            state         <= TX_DEST;
            timeout_cnt_q <= 8'h0;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 8'd1;
`endif
          end
        end
        TX_DEST: if (out_ready) state <= TX_SRC;
        TX_SRC:  if (out_ready) state <= TX_TYPE;
        TX_TYPE: if (out_ready) state <= resp_has_data ? TX_DATA : RX_DEST;
        TX_DATA: if (out_ready) state <= RX_DEST;
        default: state <= RX_DEST;
      endcase
    end
  end

  // Response flit and handshake outputs, decoded from registered state
  always_comb begin
    out      = '0;
    in_ready = 1'b0;
    unique case (state)
      RX_DEST, RX_SRC, RX_TYPE, RX_ADDR, RX_WDATA, RX_DRAIN: in_ready = 1'b1;
      TX_DEST: begin
        out.valid = 1'b1;
        out.data  = src_q;
      end
      TX_SRC: begin
        out.valid = 1'b1;
        out.data  = id;
      end
      TX_TYPE: begin
        out.valid = 1'b1;
        out.data  = type_word(resp_subtype(is_write_q, err_q));
        out.last  = !resp_has_data;
      end
      TX_DATA: begin
        out.valid = 1'b1;
        out.data  = rdata_q;
        out.last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign reg_request = reg_request_q;
  assign reg_write   = is_write_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;

endmodule

// File: tb/tb_osd_regaccess_handler.sv
// Directed bench for osd_regaccess_handler; expected values are hand-computed.
module tb_osd_regaccess_handler;
  import osd_regaccess_package::*;

  localparam logic [15:0] ID     = 16'h0010;
  localparam logic [15:0] T_RREQ = 16'h0000;
  localparam logic [15:0] T_WREQ = 16'h0400;
  localparam logic [15:0] T_RD   = 16'h2000;
  localparam logic [15:0] T_WR   = 16'h2400;
  localparam logic [15:0] T_RERR = 16'h2800;
  localparam logic [15:0] T_WERR = 16'h2C00;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id = ID;
  dii_flit     in_f, out_f;
  logic        in_ready, out_ready;
  logic        reg_request, reg_write, reg_ack, reg_err;
  logic [15:0] reg_addr, reg_wdata, reg_rdata, event_dest;
  logic        stall;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  osd_regaccess_handler #(
    .MOD_VENDOR  (16'h0001),
    .MOD_TYPE    (16'h0002),
    .MOD_VERSION (16'h0003),
    .TIMEOUT     (8'd255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id          (id),
    .in          (in_f),
    .in_ready    (in_ready),
    .out         (out_f),
    .out_ready   (out_ready),
    .reg_request (reg_request),
    .reg_write   (reg_write),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_ack     (reg_ack),
    .reg_err     (reg_err),
    .reg_rdata   (reg_rdata),
    .event_dest  (event_dest),
    .stall       (stall)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the flit was accepted
  task automatic send_flit(input logic [15:0] data, input logic last);
    int n = 0;
    in_f.valid = 1'b1;
    in_f.data  = data;
    in_f.last  = last;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_value("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_f = '0;
  endtask

  task automatic send_req(input logic [15:0] src, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata);
    send_flit(ID, 1'b0);
    send_flit(src, 1'b0);
    send_flit(wr ? T_WREQ : T_RREQ, 1'b0);
    if (wr) begin
      send_flit(addr, 1'b0);
      send_flit(wdata, 1'b1);
    end else begin
      send_flit(addr, 1'b1);
    end
  endtask

  // Returns {last, data} of the next response flit
  task automatic recv_flit(output logic [16:0] f);
    int n = 0;
    out_ready = 1'b1;
    while (!out_f.valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_f.valid) begin
      check_value("out_valid_timeout", 32'd0, 32'd1);
      f = '0;
    end else begin
      f = {out_f.last, out_f.data};
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [15:0] src, input logic [15:0] typ,
                             input logic has_data, input logic [15:0] data);
    logic [16:0] f;
    recv_flit(f);
    check_value({tag, ".dest"}, 32'(f), 32'({1'b0, src}));
    recv_flit(f);
    check_value({tag, ".src"}, 32'(f), 32'({1'b0, ID}));
    recv_flit(f);
    check_value({tag, ".type"}, 32'(f), 32'({~has_data, typ}));
    if (has_data) begin
      recv_flit(f);
      check_value({tag, ".data"}, 32'(f), 32'({1'b1, data}));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] f;
    int          cnt;
    int          vcnt;
    logic        done;
    logic        wr_seen;
    logic [15:0] addr_seen;

    in_f      = '0;
    out_ready = 1'b0;
    reg_ack   = 1'b0;
    reg_err   = 1'b0;
    reg_rdata = 16'h0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst.in_ready", 32'(in_ready), 32'd1);
    check_value("rst.out_valid", 32'(out_f.valid), 32'd0);
    check_value("rst.reg_request", 32'(reg_request), 32'd0);
    check_value("rst.event_dest", 32'(event_dest), 32'd0);
    check_value("rst.stall", 32'(stall), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Vendor ID read
    send_req(16'h0005, 1'b0, 16'h0000, 16'h0);
    expect_resp("rd_vendor", 16'h0005, T_RD, 1'b1, 16'h0001);

    // MOD_CS write: stall drops the cycle after ACCESS
    send_req(16'h0005, 1'b1, 16'h0004, 16'h0001);
    check_value("cs.stall_in_access", 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_value("cs.stall_after", 32'(stall), 32'd0);
    expect_resp("wr_cs", 16'h0005, T_WR, 1'b0, 16'h0);

    // Module register read, ack on the third request cycle
    send_req(16'h0007, 1'b0, 16'h0200, 16'h0);
    check_value("ext.req_in_access", 32'(reg_request), 32'd0);
    cnt = 0; done = 1'b0; wr_seen = 1'b1; addr_seen = 16'h0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      reg_ack = 1'b0;
      if (reg_request) begin
        cnt++;
        wr_seen   = reg_write;
        addr_seen = reg_addr;
        if (cnt == 3) begin
          reg_ack   = 1'b1;
          reg_rdata = 16'hBEEF;
        end
      end else if (cnt > 0) begin
        done = 1'b1;
      end
    end
    reg_ack = 1'b0;
    check_value("ext.req_cycles", 32'(cnt), 32'd3);
    check_value("ext.reg_write", 32'(wr_seen), 32'd0);
    check_value("ext.reg_addr", 32'(addr_seen), 32'h0200);
    expect_resp("rd_ext", 16'h0007, T_RD, 1'b1, 16'hBEEF);

    // Module register write answered with reg_err
    send_req(16'h0006, 1'b1, 16'h0400, 16'hABCD);
    cnt = 0;
    while (!reg_request && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check_value("exterr.reg_write", 32'(reg_write), 32'd1);
    check_value("exterr.reg_wdata", 32'(reg_wdata), 32'hABCD);
    reg_ack = 1'b1;
    reg_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reg_ack = 1'b0;
    reg_err = 1'b0;
    expect_resp("wr_ext_err", 16'h0006, T_WERR, 1'b0, 16'h0);

    // Writes to read-only ID registers are rejected
    send_req(16'h0005, 1'b1, 16'h0001, 16'h1111);
    expect_resp("wr_ro", 16'h0005, T_WERR, 1'b0, 16'h0);

    // event_dest write then read back
    send_req(16'h0008, 1'b1, 16'h0003, 16'h1234);
    expect_resp("wr_evd", 16'h0008, T_WR, 1'b0, 16'h0);
    check_value("evd.port", 32'(event_dest), 32'h1234);
    send_req(16'h0008, 1'b0, 16'h0003, 16'h0);
    expect_resp("rd_evd", 16'h0008, T_RD, 1'b1, 16'h1234);

    // Truncated packet (last on type flit) is dropped silently
    send_flit(ID, 1'b0);
    send_flit(16'h0009, 1'b0);
    send_flit(T_RREQ, 1'b1);
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_f.valid) vcnt++;
      @(negedge clk);
    end
    check_value("drop.no_resp", 32'(vcnt), 32'd0);
    check_value("drop.in_ready", 32'(in_ready), 32'd1);
    send_req(16'h0005, 1'b0, 16'h0002, 16'h0);
    expect_resp("rd_version", 16'h0005, T_RD, 1'b1, 16'h0003);

    // Backpressure on TX_SRC: data held, no input accepted
    send_req(16'h0005, 1'b0, 16'h0004, 16'h0);
    recv_flit(f);
    check_value("bp.dest", 32'(f), 32'h0_0005);
    for (int i = 0; i < 10; i++) begin
      check_value("bp.hold", 32'({in_ready, out_f.valid, out_f.data}), 32'({1'b0, 1'b1, ID}));
      @(negedge clk);
    end
    recv_flit(f);
    check_value("bp.src", 32'(f), 32'({1'b0, ID}));
    recv_flit(f);
    check_value("bp.type", 32'(f), 32'({1'b0, T_RD}));
    recv_flit(f);
    check_value("bp.data", 32'(f), 32'h1_0001);

    // Unknown subtype drained and answered RESP_READ_ERR
    send_flit(ID, 1'b0);
    send_flit(16'h000A, 1'b0);
    send_flit(16'h0800, 1'b0);
    send_flit(16'h0000, 1'b1);
    expect_resp("bad_type", 16'h000A, T_RERR, 1'b0, 16'h0);

    // Read with an extra trailing flit
    send_flit(ID, 1'b0);
    send_flit(16'h000B, 1'b0);
    send_flit(T_RREQ, 1'b0);
    send_flit(16'h0000, 1'b0);
    send_flit(16'h5555, 1'b1);
    expect_resp("rd_long", 16'h000B, T_RERR, 1'b0, 16'h0);

    // Reserved base range
    send_req(16'h0005, 1'b0, 16'h0100, 16'h0);
    expect_resp("rd_rsvd", 16'h0005, T_RERR, 1'b0, 16'h0);

    // Reset mid-packet: packet abandoned, registers cleared
    send_flit(ID, 1'b0);
    send_flit(16'h000C, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_value("midrst.stall", 32'(stall), 32'd1);
    check_value("midrst.event_dest", 32'(event_dest), 32'd0);
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_f.valid || !in_ready) vcnt++;
      @(negedge clk);
    end
    check_value("midrst.idle", 32'(vcnt), 32'd0);
    send_req(16'h0005, 1'b0, 16'h0000, 16'h0);
    expect_resp("rd_after_rst", 16'h0005, T_RD, 1'b1, 16'h0001);

`ifdef OSD_REGACCESS_TIMEOUT_EN
    // No reg_ack: request times out after 255 cycles
    send_req(16'h0005, 1'b0, 16'h0300, 16'h0);
    cnt = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (reg_request) cnt++;
      else if (cnt > 0) done = 1'b1;
    end
    check_value("tmo.req_cycles", 32'(cnt), 32'd255);
    expect_resp("tmo", 16'h0005, T_RERR, 1'b0, 16'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/osd_regaccess_handler.md
OSD_REGACCESS_HANDLER -- requirements
Module: osd_regaccess_handler

Interface
REQ-001 Parameters SHALL be: MOD_VENDOR 16'h0 (vendor ID at 0x0000); MOD_TYPE 16'h0 (type ID at 0x0001); MOD_VERSION 16'h0 (version at 0x0002); TIMEOUT 8'd255 (module-register ack timeout in cycles).
REQ-002 clk input 1: sole clock, rising edge.
REQ-003 rst input 1: synchronous, active-high reset.
REQ-004 id input 16: own DII address, used as the response source.
REQ-005 in input dii_flit: request flits (data, last, valid) from the regaccess demux register output.
REQ-006 in_ready output 1: request flit accepted when in.valid & in_ready.
REQ-007 out output dii_flit: response flits toward the debug NoC.
REQ-008 out_ready input 1: response flit consumed when out.valid & out_ready.
REQ-009 reg_request output 1: module-register access strobe, held until reg_ack.
REQ-010 reg_write output 1: 1 for write, 0 for read, stable while reg_request.
REQ-011 reg_addr output 16 and reg_wdata output 16: access address and write data, stable while reg_request.
REQ-012 reg_ack input 1, reg_err input 1 and reg_rdata input 16: completion, error flag and read data, sampled when reg_ack=1.
REQ-013 event_dest output 16: contents of register 0x0003.
REQ-014 stall output 1: inverse of MOD_CS bit 0.

Function
REQ-015 Request format SHALL be: flit0 dest, flit1 src, flit2 type, flit3 addr, and for writes flit4 wdata.
REQ-016 Type encoding SHALL be: [15:14]=00; [13:10] 0000 REQ_READ, 0001 REQ_WRITE, 1000 RESP_READ, 1001 RESP_WRITE, 1010 RESP_READ_ERR, 1011 RESP_WRITE_ERR; [9:0]=0.
REQ-017 FSM states SHALL be RX_DEST, RX_SRC, RX_TYPE, RX_ADDR, RX_WDATA, RX_DRAIN, ACCESS, TX_DEST, TX_SRC, TX_TYPE, TX_DATA.
REQ-018 in_ready SHALL be 1 only in RX_* states; out.valid SHALL be 1 only in TX_* states.
REQ-019 in.last on flit0–2, or on flit3 of a write, SHALL discard the packet silently and return to RX_DEST.
REQ-020 A packet with an unknown subtype, or with flits beyond the expected count, SHALL be drained to last in RX_DRAIN and then answered with the matching *_ERR response (an unknown subtype uses RESP_READ_ERR).
REQ-021 Base registers SHALL be handled internally in one ACCESS cycle: 0x0000–0x0002 read-only, with writes answered *_ERR; 0x0003 event_dest RW; 0x0004 MOD_CS RW with bit 0 = active and other bits reading 0.
REQ-022 Addresses 0x0005–0x01FF SHALL be answered *_ERR.
REQ-023 Addresses ≥0x0200 SHALL assert reg_request in the cycle after ACCESS entry and wait for reg_ack; reg_err=1 SHALL give *_ERR.
REQ-024 The response SHALL be sent as: TX_DEST = captured src, TX_SRC = id, TX_TYPE; TX_DATA follows only for a successful read (rdata, last=1); otherwise last=1 on TX_TYPE.
REQ-025 Each TX state SHALL hold out.data stable until out_ready; after the last flit the FSM SHALL return to RX_DEST.
REQ-026 A register write SHALL take effect in the ACCESS cycle, before the response is sent.

Reset
REQ-027 rst SHALL set the FSM to RX_DEST, in_ready=1, out.valid=0, reg_request=0, event_dest=0, MOD_CS=0 (stall=1) and the timeout counter to 0.
REQ-028 rst mid-packet SHALL abandon the packet and send no response.

Configuration
REQ-029 With OSD_REGACCESS_TIMEOUT_EN defined, an 8-bit counter SHALL count reg_request cycles, and on reaching TIMEOUT it SHALL drop reg_request and respond *_ERR; a later reg_ack SHALL be ignored.
REQ-030 Without OSD_REGACCESS_TIMEOUT_EN, the block SHALL wait for reg_ack indefinitely and contain no counter.

Structure
REQ-031 The type encodings, base register addresses and the FSM state enum SHALL live in a shared package, osd_regaccess_package.
REQ-032 Base-register storage and read muxing SHALL be one sub-module, osd_regaccess_baseregs; FSM and framing stay in the top.

Verification
REQ-033 Read 0x0000 with MOD_VENDOR=16'h0001, src=16'h0005, id=16'h0010 -> response {0005, 0010, RESP_READ, 0001 last}.
REQ-034 Write 0x0004 data 16'h0001 -> stall goes 1→0 the cycle after ACCESS; response {src, id, RESP_WRITE last}.
REQ-035 Read 0x0200 with reg_ack after 3 cycles, reg_rdata=16'hBEEF -> reg_request high 3 cycles, reg_write=0, reply data BEEF.
REQ-036 Write 0x0001 -> RESP_WRITE_ERR; packet with last on flit2 -> no response, next packet served normally.
REQ-037 out_ready held 0 for 10 cycles during TX_SRC -> out.data stable and in_ready=0 throughout.
REQ-038 With OSD_REGACCESS_TIMEOUT_EN and reg_ack never asserted -> RESP_READ_ERR after 255 request cycles.
